// File: rtl/neuron_timestep_scheduler.sv
// Timestep sequencer for the SNN core: integrates, leaks, thresholds and fires every neuron in turn.
// Optional NEURON_SCHED_SAT_EN clamps the reduced potential to [-128,127] instead of wrapping.
module neuron_timestep_scheduler #(
  parameter int NUM_NEURONS = 256,
  parameter int NUM_AXONS   = 256,
  parameter int NEURON_W    = 8,
  parameter int AXON_W      = 8,
  parameter int ACC_W       = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic                       start_i,
  input  logic [NUM_AXONS-1:0]       axon_spike_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NEURON_W-1:0]        neuron_sel_o,
  input  logic [7:0]                 voltage_i,
  input  logic [7:0]                 leak_i,
  input  logic [7:0]                 pos_threshold_i,
  input  logic [7:0]                 neg_threshold_i,
  input  logic [7:0]                 pos_reset_i,
  input  logic [7:0]                 neg_reset_i,
  input  logic [7:0]                 weight1_i,
  input  logic [7:0]                 weight2_i,
  input  logic [7:0]                 weight3_i,
  input  logic [7:0]                 weight4_i,
  output logic                       syn_rd_o,
  output logic [NEURON_W+AXON_W-1:0] syn_addr_o,
  input  logic [2:0]                 syn_data_i,
  output logic                       vp_wr_en_o,
  output logic [7:0]                 vp_wr_data_o,
  output logic                       spike_valid_o,
  output logic [NEURON_W-1:0]        spike_id_o,
  input  logic                       spike_ready_i,
  output logic [2:0]                 state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INTEG = 3'd2,
    LEAK  = 3'd3,
    FIRE  = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int CW = AXON_W + 1;
  localparam logic [CW-1:0]             LAST_K = CW'(NUM_AXONS);
  localparam logic [NEURON_W-1:0]       LAST_N = NEURON_W'(NUM_NEURONS - 1);
  localparam logic signed [ACC_W-1:0]   MAX8   = ACC_W'(127);
  localparam logic signed [ACC_W-1:0]   MIN8   = ACC_W'(-128);

  state_t                    state_q, state_d;
  logic [NEURON_W-1:0]       neuron_q;
  logic [CW-1:0]             cnt_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [NUM_AXONS-1:0]      spike_q;

  logic [7:0]                w_sel;
  logic [AXON_W-1:0]         axon_idx;
  logic                      add_en;
  logic signed [ACC_W-1:0]   volt_ext, leak_ext, w_ext;
  logic signed [7:0]         r;
  logic                      fire_pos, fire_neg;
  logic [7:0]                new_v;
  logic                      last_n;

  // Synapse data for axon k returns one cycle after its read, so cycle k+1 adds axon k.
  always_comb begin
    w_sel = weight1_i;
    case (syn_data_i[1:0])
      2'd0:    w_sel = weight1_i;
      2'd1:    w_sel = weight2_i;
      2'd2:    w_sel = weight3_i;
      default: w_sel = weight4_i;
    endcase
  end

  assign axon_idx = cnt_q[AXON_W-1:0] - 1'b1;
  assign add_en   = (state_q == INTEG) && (cnt_q != '0) && syn_data_i[2] && spike_q[axon_idx];
  assign volt_ext = {{(ACC_W-8){voltage_i[7]}}, voltage_i};
  assign leak_ext = {{(ACC_W-8){leak_i[7]}}, leak_i};
  assign w_ext    = {{(ACC_W-8){w_sel[7]}}, w_sel};
  assign last_n   = (neuron_q == LAST_N);

  always_comb begin
    r = acc_q[7:0];
`ifdef NEURON_SCHED_SAT_EN
    if (acc_q > MAX8)      r = 8'h7f;
    else if (acc_q < MIN8) r = 8'h80;
`endif
  end

  assign fire_pos = (r >= $signed(pos_threshold_i));
  assign fire_neg = (r <  $signed(neg_threshold_i));

  always_comb begin
    new_v = r;
    if (fire_pos)      new_v = pos_reset_i;
    else if (fire_neg) new_v = neg_reset_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Spike handshake: spike_valid_o rises in EMIT and holds, with spike_id_o stable,
  // until the cycle spike_ready_i is high; transfer happens on that edge.
  always_comb begin
    state_d       = state_q;
    busy_o        = (state_q != IDLE);
    done_o        = 1'b0;
    neuron_sel_o  = neuron_q;
    syn_rd_o      = 1'b0;
    syn_addr_o    = '0;
    vp_wr_en_o    = 1'b0;
    vp_wr_data_o  = 8'h00;
    spike_valid_o = 1'b0;
    spike_id_o    = '0;
    state_o       = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = LOAD;
      LOAD: state_d = INTEG;
      INTEG: begin
        if (cnt_q != LAST_K) begin
          syn_rd_o   = 1'b1;
          syn_addr_o = {neuron_q, cnt_q[AXON_W-1:0]};
        end else begin
          state_d = LEAK;
        end
      end
      LEAK: state_d = FIRE;
      FIRE: begin
        vp_wr_en_o   = 1'b1;
        vp_wr_data_o = new_v;
        if (fire_pos)    state_d = EMIT;
        else if (last_n) state_d = DONE;
        else             state_d = INTEG;
      end
      EMIT: begin
        spike_valid_o = 1'b1;
        spike_id_o    = neuron_q;
        if (spike_ready_i) state_d = last_n ? DONE : INTEG;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      neuron_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      spike_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) spike_q <= axon_spike_i;
        LOAD: begin
          neuron_q <= '0;
          cnt_q    <= '0;
        end
        INTEG: begin
          if (cnt_q == '0) acc_q <= volt_ext;
          else if (add_en) acc_q <= acc_q + w_ext;
          cnt_q <= (cnt_q == LAST_K) ? '0 : cnt_q + 1'b1;
        end
        LEAK: acc_q <= acc_q + leak_ext;
        FIRE: if (!fire_pos && !last_n) neuron_q <= neuron_q + 1'b1;
        EMIT: if (spike_ready_i && !last_n) neuron_q <= neuron_q + 1'b1;
        DONE: neuron_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_timestep_scheduler.sv
// Scoreboard bench for neuron_timestep_scheduler on a 4x4 core with a small synapse/parameter model.
module tb_neuron_timestep_scheduler;
  localparam int NN = 4, NA = 4, NW = 2, AW = 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [NA-1:0] axon_spike = '0;
  logic busy, done, syn_rd, vp_we, spk_v;
  logic spk_rdy = 1'b0;
  logic [NW-1:0] nsel, spk_id;
  logic [NW+AW-1:0] syn_addr;
  logic [2:0] syn_data = 3'b000;
  logic [2:0] state;
  logic [7:0] vp_wd;
  logic [7:0] voltage, leak, pos_th, neg_th, pos_rst, neg_rst, w1, w2, w3, w4;

  logic [7:0] p_volt[NN], p_leak[NN], p_pth[NN], p_nth[NN], p_prst[NN], p_nrst[NN];
  logic [7:0] p_w1[NN], p_w2[NN], p_w3[NN], p_w4[NN];
  logic [2:0] syn_mem[NN*NA];

  logic [7:0] wr_exp_q[$];
  logic [7:0] spk_exp_q[$];
  logic [7:0] hold_exp_q[$];

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, c0 = 0, exp_done = 0, done_cnt = 0;
  int hold = 0, sel_moved = 0;
  int stall_target = 0, stall_cnt = 0;
  logic [NW-1:0] sel_first = '0;

  neuron_timestep_scheduler #(
    .NUM_NEURONS(NN), .NUM_AXONS(NA), .NEURON_W(NW), .AXON_W(AW), .ACC_W(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .axon_spike_i(axon_spike),
    .busy_o(busy), .done_o(done), .neuron_sel_o(nsel),
    .voltage_i(voltage), .leak_i(leak), .pos_threshold_i(pos_th), .neg_threshold_i(neg_th),
    .pos_reset_i(pos_rst), .neg_reset_i(neg_rst),
    .weight1_i(w1), .weight2_i(w2), .weight3_i(w3), .weight4_i(w4),
    .syn_rd_o(syn_rd), .syn_addr_o(syn_addr), .syn_data_i(syn_data),
    .vp_wr_en_o(vp_we), .vp_wr_data_o(vp_wd),
    .spike_valid_o(spk_v), .spike_id_o(spk_id), .spike_ready_i(spk_rdy),
    .state_o(state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // parameter array and synapse SRAM models
  assign voltage = p_volt[nsel];
  assign leak    = p_leak[nsel];
  assign pos_th  = p_pth[nsel];
  assign neg_th  = p_nth[nsel];
  assign pos_rst = p_prst[nsel];
  assign neg_rst = p_nrst[nsel];
  assign w1 = p_w1[nsel];
  assign w2 = p_w2[nsel];
  assign w3 = p_w3[nsel];
  assign w4 = p_w4[nsel];
  always @(posedge clk) syn_data <= syn_rd ? syn_mem[syn_addr] : 3'b000;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // router model: hold ready low for stall_target valid cycles, then accept
  initial forever begin
    @(posedge clk); #1;
    if (spk_v) begin
      if (stall_cnt < stall_target) begin stall_cnt++; spk_rdy = 1'b0; end
      else begin stall_cnt = 0; spk_rdy = 1'b1; end
    end else begin
      spk_rdy = 1'b0;
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a write, spike or done
  always @(negedge clk) begin
    if (rst_n) begin
      if (vp_we) begin
        check("wr_expected", int'(wr_exp_q.size() != 0), 1);
        if (wr_exp_q.size() != 0) check("wr_data", int'(vp_wd), int'(wr_exp_q.pop_front()));
      end
      if (spk_v) begin
        if (hold == 0) sel_first = nsel;
        else if (nsel != sel_first) sel_moved = 1;
        hold++;
        if (spk_rdy) begin
          check("spike_expected", int'(spk_exp_q.size() != 0), 1);
          if (spk_exp_q.size() != 0) begin
            check("spike_id", int'(spk_id), int'(spk_exp_q.pop_front()));
            check("spike_hold", hold, int'(hold_exp_q.pop_front()));
            check("sel_stable", sel_moved, 0);
          end
          hold = 0;
          sel_moved = 0;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_cycle", cyc - c0 + 1, exp_done);
      end
    end
  end

  // driver tasks
  task automatic clear_env();
    for (int i = 0; i < NN; i++) begin
      p_volt[i] = 8'h00; p_leak[i] = 8'h00; p_prst[i] = 8'h00; p_nrst[i] = 8'h00;
      // band [-128,127) keeps a zero potential quiet
      p_pth[i] = 8'd127; p_nth[i] = 8'h80;
      p_w1[i] = 8'h00; p_w2[i] = 8'h00; p_w3[i] = 8'h00; p_w4[i] = 8'h00;
    end
    for (int i = 0; i < NN*NA; i++) syn_mem[i] = 3'b000;
    axon_spike = '0;
    stall_target = 0;
  endtask

  task automatic push_writes(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
    wr_exp_q.push_back(a); wr_exp_q.push_back(b);
    wr_exp_q.push_back(c); wr_exp_q.push_back(d);
  endtask

  task automatic start_ts();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int done0);
    int n = 0;
    while (done_cnt == done0 && n < 500) begin @(posedge clk); n++; end
    check("done_seen", done_cnt - done0, 1);
    @(posedge clk); #1;
    check("wr_q_empty", int'(wr_exp_q.size()), 0);
    check("spk_q_empty", int'(spk_exp_q.size()), 0);
  endtask

  task automatic run(input int exp_d);
    int done0 = done_cnt;
    exp_done = exp_d;
    start_ts();
    wait_done(done0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_sel"}, int'(nsel), 0);
    check({tag, "_syn_rd"}, int'(syn_rd), 0);
    check({tag, "_syn_addr"}, int'(syn_addr), 0);
    check({tag, "_wr_en"}, int'(vp_we), 0);
    check({tag, "_wr_data"}, int'(vp_wd), 0);
    check({tag, "_spk_v"}, int'(spk_v), 0);
    check({tag, "_spk_id"}, int'(spk_id), 0);
    check({tag, "_state"}, int'(state), 0);
  endtask

  initial begin
    int done0;
    clear_env();
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: all-zero timestep, four zero writes, done in cycle 30
    clear_env();
    push_writes(8'd0, 8'd0, 8'd0, 8'd0);
    run(30);

    // 2: 10 + 5 - 3 - 1 = 11, axon 1 connected but silent
    clear_env();
    p_volt[0] = 8'd10; p_w1[0] = 8'd5; p_w2[0] = 8'hFD; p_leak[0] = 8'hFF;
    p_pth[0] = 8'd20; p_nth[0] = 8'hE7;
    syn_mem[0] = 3'b100; syn_mem[1] = 3'b100; syn_mem[2] = 3'b101;
    axon_spike = 4'b0101;
    push_writes(8'd11, 8'd0, 8'd0, 8'd0);
    run(30);

    // 3: 15 + 10 = 25 fires, router stalls 3 cycles
    clear_env();
    p_volt[0] = 8'd15; p_w1[0] = 8'd10; p_pth[0] = 8'd20; p_prst[0] = 8'd0;
    syn_mem[0] = 3'b100; axon_spike = 4'b0001; stall_target = 3;
    push_writes(8'd0, 8'd0, 8'd0, 8'd0);
    spk_exp_q.push_back(8'd0); hold_exp_q.push_back(8'd4);
    run(34);

    // 3b: last neuron fires with immediate accept, EMIT goes straight to DONE
    clear_env();
    p_volt[3] = 8'd15; p_w1[3] = 8'd10; p_pth[3] = 8'd20; p_prst[3] = 8'd3;
    syn_mem[12] = 3'b100; axon_spike = 4'b0001;
    push_writes(8'd0, 8'd0, 8'd0, 8'd3);
    spk_exp_q.push_back(8'd3); hold_exp_q.push_back(8'd1);
    run(31);

    // 4: -10 - 20 = -30 < -25 writes neg_reset 5
    clear_env();
    p_volt[0] = 8'hF6; p_w1[0] = 8'hEC; p_nth[0] = 8'hE7; p_nrst[0] = 8'd5;
    syn_mem[0] = 3'b100; axon_spike = 4'b0001;
    push_writes(8'd5, 8'd0, 8'd0, 8'd0);
    run(30);

    // 5: -100 - 100 = -200 overflows 8 bits
    clear_env();
    p_volt[0] = 8'h9C; p_w1[0] = 8'h9C; p_nth[0] = 8'h80; p_pth[0] = 8'd100;
    syn_mem[0] = 3'b100; axon_spike = 4'b0001;
`ifdef NEURON_SCHED_SAT_EN
    push_writes(8'h80, 8'd0, 8'd0, 8'd0);
`else
    push_writes(8'd56, 8'd0, 8'd0, 8'd0);
`endif
    run(30);

    // 6a: start while busy is ignored
    clear_env();
    push_writes(8'd0, 8'd0, 8'd0, 8'd0);
    done0 = done_cnt;
    exp_done = 30;
    start_ts();
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(done0);
    repeat (40) @(posedge clk);
    #1 check("single_done", done_cnt - done0, 1);

    // 6b: reset during INTEG of neuron 2 (cycles 16..20)
    clear_env();
    wr_exp_q.push_back(8'd0); wr_exp_q.push_back(8'd0);
    done0 = done_cnt;
    exp_done = 0;
    start_ts();
    repeat (16) @(posedge clk);
    #1;
    check("abort_sel", int'(nsel), 2);
    check("abort_state", int'(state), 2);
    rst_n = 1'b0;
    #1 check_idle("abort");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_wr_q", int'(wr_exp_q.size()), 0);
    check("abort_no_done", done_cnt - done0, 0);

    // 6c: fresh start runs from neuron 0
    clear_env();
    p_volt[0] = 8'd7;
    push_writes(8'd7, 8'd0, 8'd0, 8'd0);
    run(30);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
